// File: rtl/mvb_fifo_compact_pkg.sv
// Shared helpers for the compacting MVB FIFO: bit counting, ceiling log2
// and the item index type used for prefix positions.
package mvb_fifo_pkg;

   localparam int MAX_REGIONS = 64;

   typedef int unsigned item_idx_t;

   function automatic int log2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   function automatic item_idx_t popcount(input logic [MAX_REGIONS-1:0] v);
      item_idx_t c;
      c = 0;
      for (int i = 0; i < MAX_REGIONS; i++) c += item_idx_t'(v[i]);
      return c;
   endfunction

endpackage

// File: rtl/mvb_fifo_compact_rot.sv
// Barrel rotator of REGIONS items: output region j takes input region (j - amt) mod REGIONS.
module mvb_fifo_compact_rot #(
   parameter int REGIONS = 4,
   parameter int W       = 32,
   parameter int AW      = 2
) (
   input  logic [REGIONS*W-1:0] data_i,
   input  logic [AW-1:0]        amt_i,
   output logic [REGIONS*W-1:0] data_o
);

   always_comb begin
      int src;
      src    = 0;
      data_o = '0;
      for (int j = 0; j < REGIONS; j++) begin
         src = (j + REGIONS - int'(amt_i)) % REGIONS;
         data_o[j*W +: W] = data_i[src*W +: W];
      end
   end

endmodule

// File: rtl/mvb_fifo_compact.sv
// Single-clock MVB FIFO storing only valid items, compacted in arrival order
// across REGIONS interleaved banks; TX presents the oldest items packed from region 0.
module mvb_fifo_compact
   import mvb_fifo_pkg::*;
#(
   parameter int    REGIONS       = 4,
   parameter int    ITEM_WIDTH    = 32,
   parameter int    FIFO_ITEMS    = 64,
   parameter int    AFULL_OFFSET  = 8,
   parameter int    AEMPTY_OFFSET = 4,
   parameter string DEVICE        = "ULTRASCALE"
) (
   input  logic                          CLK,
   input  logic                          RESET_N,
   input  logic [REGIONS*ITEM_WIDTH-1:0] RX_DATA,
   input  logic [REGIONS-1:0]            RX_VLD,
   input  logic                          RX_SRC_RDY,
   output logic                          RX_DST_RDY,
   output logic [REGIONS*ITEM_WIDTH-1:0] TX_DATA,
   output logic [REGIONS-1:0]            TX_VLD,
   output logic                          TX_SRC_RDY,
   input  logic                          TX_DST_RDY,
   output logic [log2(FIFO_ITEMS):0]     STATUS,
   output logic                          AFULL,
   output logic                          AEMPTY
);

   localparam int PW   = log2(FIFO_ITEMS);
   localparam int CW   = PW + 1;
   localparam int RW   = log2(REGIONS);
   localparam int SW   = (RW > 0) ? RW : 1;
   localparam int ROWS = FIFO_ITEMS / REGIONS;
   localparam int ROWW = PW - RW;
   localparam int EW   = ITEM_WIDTH + 1;

   logic [PW-1:0]                 wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]                 count_q, count_d;
   logic                          rx_rdy_q, rx_rdy_d;
   logic                          wr_fire, rd_fire;
   logic [CW-1:0]                 wr_n, rd_n;
   logic [SW-1:0]                 wr_sh, rd_sh, tx_amt;
   logic [REGIONS*EW-1:0]         comp_word, rx_rot;
   logic [REGIONS*ITEM_WIDTH-1:0] bank_rword;
   logic [REGIONS-1:0]            bank_we;
   logic [ITEM_WIDTH-1:0]         bank_wdata [REGIONS];
   logic [ITEM_WIDTH-1:0]         bank_rdata [REGIONS];
   logic [PW-1:0]                 w_slot     [REGIONS];
   logic [PW-1:0]                 r_slot     [REGIONS];

   assign wr_fire = RX_SRC_RDY & rx_rdy_q;
   assign rd_fire = TX_SRC_RDY & TX_DST_RDY;
   assign wr_n    = wr_fire ? CW'(popcount(MAX_REGIONS'(RX_VLD))) : '0;
   assign rd_n    = !rd_fire ? '0 : ((count_q >= CW'(REGIONS)) ? CW'(REGIONS) : count_q);
   assign wr_sh   = SW'(int'(wr_ptr_q) % REGIONS);
   assign rd_sh   = SW'(int'(rd_ptr_q) % REGIONS);
   assign tx_amt  = SW'((REGIONS - int'(rd_sh)) % REGIONS);

   // Each valid item lands at the position given by the count of valid items below it.
   always_comb begin
      item_idx_t pos;
      pos       = 0;
      comp_word = '0;
      for (int r = 0; r < REGIONS; r++) begin
         if (RX_VLD[r]) begin
            comp_word[pos*EW +: EW] = {1'b1, RX_DATA[r*ITEM_WIDTH +: ITEM_WIDTH]};
            pos++;
         end
      end
   end

   mvb_fifo_compact_rot #(.REGIONS(REGIONS), .W(EW), .AW(SW)) u_rx_rot (
      .data_i(comp_word), .amt_i(wr_sh), .data_o(rx_rot)
   );

   // Bank b holds slots s with s mod REGIONS == b; its row is the slot's upper bits.
   always_comb begin
      bank_we = '0;
      for (int b = 0; b < REGIONS; b++) begin
         w_slot[b]     = wr_ptr_q + PW'((b + REGIONS - int'(wr_sh)) % REGIONS);
         r_slot[b]     = rd_ptr_q + PW'((b + REGIONS - int'(rd_sh)) % REGIONS);
         bank_we[b]    = wr_fire & rx_rot[b*EW + ITEM_WIDTH];
         bank_wdata[b] = rx_rot[b*EW +: ITEM_WIDTH];
      end
   end

   for (genvar b = 0; b < REGIONS; b++) begin : g_bank
      if (DEVICE == "ULTRASCALE" || DEVICE == "7SERIES") begin : g_xilinx
         (* ram_style = "distributed" *) logic [ITEM_WIDTH-1:0] mem_q [ROWS];
         always_ff @(posedge CLK) if (bank_we[b]) mem_q[w_slot[b][PW-1 -: ROWW]] <= bank_wdata[b];
         assign bank_rdata[b] = mem_q[r_slot[b][PW-1 -: ROWW]];
      end else begin : g_generic
         logic [ITEM_WIDTH-1:0] mem_q [ROWS];
         always_ff @(posedge CLK) if (bank_we[b]) mem_q[w_slot[b][PW-1 -: ROWW]] <= bank_wdata[b];
         assign bank_rdata[b] = mem_q[r_slot[b][PW-1 -: ROWW]];
      end
      assign bank_rword[b*ITEM_WIDTH +: ITEM_WIDTH] = bank_rdata[b];
   end

   mvb_fifo_compact_rot #(.REGIONS(REGIONS), .W(ITEM_WIDTH), .AW(SW)) u_tx_rot (
      .data_i(bank_rword), .amt_i(tx_amt), .data_o(TX_DATA)
   );

   // Ready looks only at the post-edge count, so a same-edge pop never admits extra items.
   always_comb begin
      wr_ptr_d = wr_ptr_q + PW'(wr_n);
      rd_ptr_d = rd_ptr_q + PW'(rd_n);
      count_d  = count_q + wr_n - rd_n;
      rx_rdy_d = (int'(count_d) <= FIFO_ITEMS - REGIONS);
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         rx_rdy_q <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         rx_rdy_q <= rx_rdy_d;
      end
   end

   always_comb begin
      TX_VLD = '0;
      for (int k = 0; k < REGIONS; k++) TX_VLD[k] = (int'(count_q) > k);
   end

   assign TX_SRC_RDY = (count_q != '0);
   assign RX_DST_RDY = rx_rdy_q;
   assign STATUS     = count_q;
   assign AFULL      = ((FIFO_ITEMS - int'(count_q)) <= AFULL_OFFSET);
   assign AEMPTY     = (int'(count_q) <= AEMPTY_OFFSET);

endmodule
